// File: rtl/cgra_bus_pkg.sv
// Shared definitions for the CGRA bus arbiter.
// Holds parameter defaults and the tenure state encoding.
package cgra_bus_pkg;

    localparam int N_PE_DEF     = 4;
    localparam int MAX_WAIT_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_GRANT = 2'd1;
    localparam state_t S_WAIT  = 2'd2;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: first requester above last, wrapping.
// Purely combinational.
module rr_picker #(
    parameter int N_PE = 4
) (
    input  logic [N_PE-1:0]         req,
    input  logic [$clog2(N_PE)-1:0] last,
    output logic [N_PE-1:0]         win,
    output logic [$clog2(N_PE)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(N_PE);

    int   j;
    logic found;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_PE; k++) begin
            j = (int'(last) + k) % N_PE;
            if (!found && req[j]) begin
                found  = 1'b1;
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the PE shared bus: one-cycle grant pulse,
// then a tenure closed by txn_done or by a MAX_WAIT timeout.
module bus_arbiter
    import cgra_bus_pkg::*;
#(
    parameter int N_PE     = N_PE_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_PE-1:0]         bus_request,
    input  logic                    txn_done,
    output logic [N_PE-1:0]         grant,
    output logic [$clog2(N_PE)-1:0] owner_id,
    output logic                    bus_busy,
    output logic                    timeout_err
);

    localparam int IW = $clog2(N_PE);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    state_t          state;
    logic [IW-1:0]   last_owner;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [N_PE-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            any;

    assign cnt_inc = cnt + CW'(1);

    rr_picker #(
        .N_PE(N_PE)
    ) u_pick (
        .req (bus_request),
        .last(last_owner),
        .win (win),
        .idx (win_idx),
        .any (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= '0;
            owner_id    <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            last_owner  <= IW'(N_PE - 1);
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any) begin
                        state      <= S_GRANT;
                        grant      <= win;
                        owner_id   <= win_idx;
                        last_owner <= win_idx;
                        cnt        <= '0;
                        bus_busy   <= 1'b1;
                    end
                end
                S_GRANT: begin
                    state <= S_WAIT;
                    grant <= '0;
                end
                S_WAIT: begin
                    // txn_done beats a timeout landing in the same cycle
                    if (txn_done) begin
                        state    <= S_IDLE;
                        bus_busy <= 1'b0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state       <= S_IDLE;
                        bus_busy    <= 1'b0;
                        timeout_err <= 1'b1;
                        cnt         <= cnt_inc;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    grant    <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: tenure-age reference model
// compared every cycle, plus directed literal scenarios.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int MW = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] bus_request;
    logic         txn_done;
    logic [N-1:0] grant;
    logic [1:0]   owner_id;
    logic         bus_busy;
    logic         timeout_err;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N_PE    (N),
        .MAX_WAIT(MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_request(bus_request),
        .txn_done   (txn_done),
        .grant      (grant),
        .owner_id   (owner_id),
        .bus_busy   (bus_busy),
        .timeout_err(timeout_err)
    );

    int tests = 0;
    int fails = 0;

    // age -1: no tenure; 0: grant cycle; k>=1: k-th wait cycle
    int m_age   = -1;
    int m_owner = 0;
    int m_last  = N - 1;
    bit m_terr  = 1'b0;
    bit armed   = 1'b0;

    logic [N-1:0] gq[$];
    int pe2_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_age   = -1;
            m_owner = 0;
            m_last  = N - 1;
            m_terr  = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            m_terr = 1'b0;
            if (m_age < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_age < 0 && bus_request[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_last  = m_owner;
                        m_age   = 0;
                    end
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (txn_done) begin
                m_age = -1;
            end else if (m_age == MW) begin
                m_age  = -1;
                m_terr = 1'b1;
            end else begin
                m_age++;
            end
        end
        #1;
        if (armed) begin
            chk("grant", 32'(grant),
                (m_age == 0) ? (32'd1 << m_owner) : 32'd0);
            chk("owner_id", 32'(owner_id), 32'(m_owner));
            chk("bus_busy", 32'(bus_busy), 32'(m_age >= 0));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            if (grant != 0) gq.push_back(grant);
            if (grant[2] === 1'b1) pe2_cnt++;
        end
    end

    int first;
    int tcount;
    int busy_at;
    int pe2_base;

    initial begin
        reset       = 1'b1;
        bus_request = '0;
        txn_done    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_owner", 32'(owner_id), 32'd0);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        // all PEs requesting: rotation 0,1,2,3,0
        gq.delete();
        bus_request = 4'b1111;
        repeat (30) begin
            @(negedge clk);
            txn_done = (m_age == 2);
        end
        bus_request = '0;
        txn_done    = 1'b1;
        repeat (4) @(negedge clk);
        txn_done = 1'b0;
        @(negedge clk);
        chk("rr_count_ge5", 32'(gq.size() >= 5), 32'd1);
        if (gq.size() >= 5) begin
            chk("rr_g0", 32'(gq[0]), 32'h1);
            chk("rr_g1", 32'(gq[1]), 32'h2);
            chk("rr_g2", 32'(gq[2]), 32'h4);
            chk("rr_g3", 32'(gq[3]), 32'h8);
            chk("rr_g4", 32'(gq[4]), 32'h1);
        end
        chk("rr_idle", 32'(bus_busy), 32'd0);

        // single request, one-cycle latency
        bus_request = 4'b0100;
        @(negedge clk);
        bus_request = '0;
        chk("lat_grant", 32'(grant), 32'h4);
        chk("lat_owner", 32'(owner_id), 32'd2);
        chk("lat_busy", 32'(bus_busy), 32'd1);
        @(negedge clk);
        chk("lat_grant_off", 32'(grant), 32'h0);
        chk("lat_busy_wait", 32'(bus_busy), 32'd1);
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        chk("lat_done_idle", 32'(bus_busy), 32'd0);

        // timeout on PE1 tenure
        bus_request = 4'b0010;
        first  = -1;
        tcount = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus_request = '0;
            if (timeout_err === 1'b1) begin
                tcount++;
                if (first < 0) first = i;
            end
        end
        chk("to_cycle", 32'(first), 32'd10);
        chk("to_pulses", 32'(tcount), 32'd1);
        chk("to_owner", 32'(owner_id), 32'd1);
        chk("to_idle", 32'(bus_busy), 32'd0);

        // txn_done coincides with timeout
        bus_request = 4'b0001;
        tcount  = 0;
        busy_at = -1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus_request = '0;
            txn_done    = (i == 9);
            if (timeout_err === 1'b1) tcount++;
            if (i == 10) busy_at = int'(bus_busy);
        end
        chk("tie_terr", 32'(tcount), 32'd0);
        chk("tie_idle", 32'(busy_at), 32'd0);

        // reset mid-wait with owner 3
        bus_request = 4'b1000;
        @(negedge clk);
        bus_request = '0;
        @(negedge clk);
        chk("rw_owner3", 32'(owner_id), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rw_grant", 32'(grant), 32'd0);
        chk("rw_owner", 32'(owner_id), 32'd0);
        chk("rw_busy", 32'(bus_busy), 32'd0);
        chk("rw_terr", 32'(timeout_err), 32'd0);
        reset       = 1'b0;
        bus_request = 4'b1001;
        @(negedge clk);
        bus_request = '0;
        chk("rw_pe0_first", 32'(grant), 32'h1);
        @(negedge clk);
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;

        // PE2 pulse during wait is dropped
        pe2_base    = pe2_cnt;
        bus_request = 4'b0001;
        @(negedge clk);
        bus_request = '0;
        @(negedge clk);
        bus_request = 4'b0100;
        @(negedge clk);
        bus_request = '0;
        txn_done    = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("drop_pe2", 32'(pe2_cnt - pe2_base), 32'd0);
        chk("drop_grant", 32'(grant), 32'd0);

        // randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            bus_request = ($urandom % 3 == 0) ? '0 : N'($urandom);
            txn_done    = ($urandom % 4 == 0);
            reset       = ($urandom % 250 == 0);
        end
        @(negedge clk);
        reset       = 1'b0;
        bus_request = '0;
        txn_done    = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
